// File: rtl/eth_wb_master.sv
// eth_wb_master: Wishbone classic-cycle master engine.
//
// Turns a command stream (start address, direction, byte select, beats-1) into single or
// incrementing-burst Wishbone classic cycles. Write data is taken from a valid/ready stream,
// read data is presented on a valid/ready stream, and each command ends with a one-cycle
// done_o pulse carrying err_o / tmo_o status.
//
// Ports:
//   wb_clk_i, wb_rst_n_i             clock, asynchronous active-low reset
//   cmd_*                            command stream (valid/ready, adr, we, sel, len)
//   wd_*                             write data stream in
//   rd_*                             read data stream out, rd_last_o marks the final beat
//   done_o, err_o, tmo_o, busy_o     completion and status
//   wb_*                             Wishbone classic master interface
//
// Optional feature: define ETH_WB_RETRY_EN to re-issue a beat that ends in err, up to
// RETRY_MAX times per beat, before reporting err_o.

module eth_wb_master #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned SW        = DW / 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned LW        = $clog2(MAX_BURST),
  parameter int unsigned TO_CYCLES = 255,
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic          cmd_we_i,
  input  logic [SW-1:0] cmd_sel_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic          wd_valid_i,
  output logic          wd_ready_o,
  input  logic [DW-1:0] wd_dat_i,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [DW-1:0] rd_dat_o,
  output logic          rd_last_o,
  output logic          done_o,
  output logic          err_o,
  output logic          tmo_o,
  output logic          busy_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [SW-1:0] wb_sel_o,
  output logic          wb_we_o,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam int unsigned TW = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);
  // Final count value of a waiting beat; only meaningful when TO_CYCLES != 0.
  localparam logic [TW-1:0] ToLast = TW'(TO_CYCLES - 1);
  localparam logic [AW-1:0] AdrStep = AW'(SW);

  typedef enum logic [2:0] {StIdle, StWdat, StStb, StRhold, StDone, StRetry} state_e;

  state_e        state_q;
  logic [LW-1:0] beat_q;
  logic [TW-1:0] to_q;
  logic          last_beat;
  logic          to_hit;

`ifdef ETH_WB_RETRY_EN
  localparam int unsigned RW = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);
  logic [RW-1:0] retry_q;
`else
  logic unused_retry;
  assign unused_retry = ^RETRY_MAX;
`endif

  always_comb begin
    last_beat = (beat_q == '0);
    to_hit    = (TO_CYCLES != 0) && (to_q == ToLast);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      to_q        <= '0;
`ifdef ETH_WB_RETRY_EN
      retry_q     <= '0;
`endif
      cmd_ready_o <= 1'b0;
      wd_ready_o  <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_dat_o    <= '0;
      rd_last_o   <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      tmo_o       <= 1'b0;
      busy_o      <= 1'b0;
      wb_adr_o    <= '0;
      wb_sel_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_dat_o    <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            wb_cyc_o    <= 1'b1;
            wb_adr_o    <= cmd_adr_i;
            wb_sel_o    <= cmd_sel_i;
            wb_we_o     <= cmd_we_i;
            beat_q      <= cmd_len_i;
            to_q        <= '0;
            err_o       <= 1'b0;
            tmo_o       <= 1'b0;
`ifdef ETH_WB_RETRY_EN
            retry_q     <= '0;
`endif
            if (cmd_we_i) begin
              wd_ready_o <= 1'b1;
              state_q    <= StWdat;
            end else begin
              wb_stb_o <= 1'b1;
              state_q  <= StStb;
            end
          end
        end
        StWdat: begin
          if (wd_valid_i) begin
            wb_dat_o   <= wd_dat_i;
            wd_ready_o <= 1'b0;
            wb_stb_o   <= 1'b1;
            to_q       <= '0;
            state_q    <= StStb;
          end
        end
        StStb: begin
          // err wins over a simultaneous ack; ack/err win over a timeout on the same cycle.
          if (wb_err_i) begin
            wb_stb_o <= 1'b0;
            to_q     <= '0;
`ifdef ETH_WB_RETRY_EN
            if (retry_q < RW'(RETRY_MAX)) begin
              retry_q <= retry_q + 1'b1;
              state_q <= StRetry;
            end else begin
              err_o    <= 1'b1;
              wb_cyc_o <= 1'b0;
              wb_we_o  <= 1'b0;
              done_o   <= 1'b1;
              state_q  <= StDone;
            end
`else
            err_o    <= 1'b1;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            done_o   <= 1'b1;
            state_q  <= StDone;
`endif
          end else if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            to_q     <= '0;
`ifdef ETH_WB_RETRY_EN
            retry_q  <= '0;
`endif
            if (!wb_we_o) begin
              rd_dat_o   <= wb_dat_i;
              rd_valid_o <= 1'b1;
              rd_last_o  <= last_beat;
              state_q    <= StRhold;
            end else if (!last_beat) begin
              wb_adr_o   <= wb_adr_o + AdrStep;
              beat_q     <= beat_q - 1'b1;
              wd_ready_o <= 1'b1;
              state_q    <= StWdat;
            end else begin
              wb_cyc_o <= 1'b0;
              wb_we_o  <= 1'b0;
              done_o   <= 1'b1;
              state_q  <= StDone;
            end
          end else if (to_hit) begin
            tmo_o    <= 1'b1;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            done_o   <= 1'b1;
            state_q  <= StDone;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        StRhold: begin
          if (rd_ready_i) begin
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
            if (last_beat) begin
              wb_cyc_o <= 1'b0;
              wb_we_o  <= 1'b0;
              done_o   <= 1'b1;
              state_q  <= StDone;
            end else begin
              wb_adr_o <= wb_adr_o + AdrStep;
              beat_q   <= beat_q - 1'b1;
              wb_stb_o <= 1'b1;
              state_q  <= StStb;
            end
          end
        end
        StRetry: begin
          // One idle cycle with cyc held, then the same beat is strobed again.
          wb_stb_o <= 1'b1;
          state_q  <= StStb;
        end
        StDone: begin
          busy_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/eth_wb_master.md
Name: eth_wb_master

Overview:
- Synthesisable, parametrised Wishbone classic-cycle master engine for the Ethernet subsystem.
- Converts a command stream (address, direction, byte select, burst length) into single or incrementing-burst Wishbone cycles.
- Write data arrives on a stream input; read data leaves on a stream output.
- Reports completion, bus error and timeout status.
- Replaces task-driven host access, so DMA/test logic can drive the bus from RTL.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- SW, DW/8, byte-select width. Derived; do not override.
- MAX_BURST, 16, maximum beats per command; power of 2, ≥2.
- LW, $clog2(MAX_BURST), width of the burst-length field.
- TO_CYCLES, 255, cycles an outstanding beat may wait for ack/err before timeout; 0 disables timeout.
- RETRY_MAX, 3, retries per beat. Used only with ETH_WB_RETRY_EN.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_adr_i  in  AW  start byte address.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_sel_i  in  SW  byte select, applied to every beat.
- cmd_len_i  in  LW  beats minus 1.
- wd_valid_i  in  1  write data valid.
- wd_ready_o  out  1  write data ready.
- wd_dat_i  in  DW  write data.
- rd_valid_o  out  1  read data valid.
- rd_ready_i  in  1  read data ready.
- rd_dat_o  out  DW  read data.
- rd_last_o  out  1  last beat of burst.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  bus error status, valid with done_o.
- tmo_o  out  1  timeout status, valid with done_o.
- busy_o  out  1  command in progress.
- wb_adr_o  out  AW  Wishbone address.
- wb_sel_o  out  SW  Wishbone byte select.
- wb_we_o  out  1  Wishbone write enable.
- wb_dat_o  out  DW  Wishbone write data.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_dat_i  in  DW  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.

Behaviour:
- Reset (wb_rst_n_i=0, asynchronous): all outputs 0; FSM to IDLE; counters cleared. Reset mid-cycle drops cyc/stb immediately. Pending data and status are discarded.
- States: IDLE, WDAT, STB, RHOLD, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On accept: latch adr/we/sel; beat counter = cmd_len_i; cyc_o=1 next cycle.
  - Next state is WDAT if write, else STB.
- WDAT:
  - wd_ready_o=1.
  - On wd_valid_i: register data into wb_dat_o, go to STB. stb_o=1 in the following cycle.
  - cyc_o stays 1 while waiting.
- STB:
  - stb_o=1; adr/sel/we/dat held stable until ack or err.
  - Timeout counter increments each cycle.
- ack in STB:
  - stb_o=0 next cycle.
  - Read: capture wb_dat_i into rd_dat_o, go to RHOLD.
  - Write, not last beat: adr += SW, go to WDAT.
  - Last beat: go to DONE.
- RHOLD:
  - rd_valid_o=1; rd_last_o=1 on the final beat.
  - Wait for rd_ready_i. Then go to DONE if last beat, else adr += SW and go to STB.
  - cyc_o stays 1; stb_o=0 while holding.
- err in STB (takes priority if ack and err arrive together):
  - Abort remaining beats; err_o=1; go to DONE.
  - No rd_valid_o for the erroring beat.
- Timeout: counter reaches TO_CYCLES with no ack/err → tmo_o=1, go to DONE.
- DONE:
  - cyc_o=0, stb_o=0.
  - done_o=1 for exactly one cycle.
  - err_o/tmo_o hold their values until the next command is accepted.
  - Return to IDLE.
- Address wraps modulo 2^AW. No boundary check.
- busy_o = state≠IDLE.
- Maximum throughput is 1 beat / 2 cycles (stb deasserts between beats).
- wb_we_o=0 whenever cyc_o=0.

Optional Feature:
- Macro: ETH_WB_RETRY_EN.
- Defined:
  - An err on a beat re-issues the same beat (same adr/dat) after 1 idle cycle with stb_o=0, cyc_o=1.
  - Up to RETRY_MAX retries; the retry counter resets per beat.
  - err_o is set only when retries are exhausted.
  - A timeout is not retried.
- Undefined: err aborts immediately as described above; RETRY_MAX is ignored.

Test Plan:
- Single write: adr=0x100, sel=0xF, len=0, wd=0xDEADBEEF, slave acks after 2 wait states → one cycle with adr 0x100, dat 0xDEADBEEF, we=1; done_o pulses; err_o=0; tmo_o=0.
- 4-beat read: adr=0x200, len=3, slave returns 0x11,0x22,0x33,0x44 → addresses 0x200,0x204,0x208,0x20C; rd_dat_o sequence 0x11..0x44; rd_last_o on 0x44 only. Holding rd_ready_i=0 for 5 cycles on beat 2 keeps stb_o=0 and cyc_o=1.
- Write burst with wd_valid_i gaps: len=2, wd_valid_i low 3 cycles between beats → stb_o only rises after data is taken; 3 acks; done_o pulses once.
- Error on beat 2 of 4-beat read, without macro → beats 3–4 never issued; done_o with err_o=1; rd_valid_o seen once. With macro and RETRY_MAX=3: err then ack → beat reissued at same adr; err_o=0.
- Timeout: TO_CYCLES=8, slave never responds → tmo_o=1 and done_o exactly 8 cycles after stb_o rises; cyc_o=0 next cycle.
- Reset: assert wb_rst_n_i mid-burst → cyc_o/stb_o go 0 without waiting for a clock edge. After release: cmd_ready_o=1, busy_o=0.
